// File: rtl/res_ram_arbiter.sv
// rtl/res_ram_arbiter.sv - two-port arbiter for the single-port result RAM
// Sticky grant with burst limit, round-robin fallback, 1-cycle read return.
module res_ram_arbiter #(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              res_rd,
  output logic              res_wr,
  output logic [ADDR_W-1:0] res_addr,
  output logic [DATA_W-1:0] res_do,
  input  logic [DATA_W-1:0] res_di
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  state_t           state_q, state_d;
  logic             rr_b_q, rr_b_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             a_rvalid_q, b_rvalid_q;
  logic             win_a, win_b, under_limit;

  // Grants are gated by reset so they fall the instant reset is asserted.
  always_comb begin
    win_a       = 1'b0;
    win_b       = 1'b0;
    under_limit = (burst_cnt_q < MAX_CNT);
    case (state_q)
      IDLE: begin
        if (a_req && (!b_req || !rr_b_q)) win_a = 1'b1;
        else if (b_req)                   win_b = 1'b1;
      end
      OWN_A: begin
        if (a_req && (!b_req || under_limit)) win_a = 1'b1;
        else if (b_req)                       win_b = 1'b1;
      end
      OWN_B: begin
        if (b_req && (!a_req || under_limit)) win_b = 1'b1;
        else if (a_req)                       win_a = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      win_a = 1'b0;
      win_b = 1'b0;
    end
  end

  always_comb begin
    state_d     = IDLE;
    rr_b_d      = rr_b_q;
    burst_cnt_d = burst_cnt_q;
    if (win_a) begin
      state_d     = OWN_A;
      rr_b_d      = 1'b1;
      burst_cnt_d = (state_q != OWN_A) ? CNT_ONE :
                    (under_limit ? burst_cnt_q + CNT_ONE : burst_cnt_q);
    end else if (win_b) begin
      state_d     = OWN_B;
      rr_b_d      = 1'b0;
      burst_cnt_d = (state_q != OWN_B) ? CNT_ONE :
                    (under_limit ? burst_cnt_q + CNT_ONE : burst_cnt_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_b_q      <= 1'b0;
      burst_cnt_q <= '0;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_b_q      <= rr_b_d;
      burst_cnt_q <= burst_cnt_d;
      a_rvalid_q  <= win_a & ~a_we;
      b_rvalid_q  <= win_b & ~b_we;
    end
  end

  assign a_gnt    = win_a;
  assign b_gnt    = win_b;
  assign res_addr = win_a ? a_addr  : (win_b ? b_addr  : '0);
  assign res_do   = win_a ? a_wdata : (win_b ? b_wdata : '0);
  assign res_wr   = (win_a & a_we)  | (win_b & b_we);
  assign res_rd   = (win_a & ~a_we) | (win_b & ~b_we);

  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_rdata  = a_rvalid_q ? res_di : '0;
  assign b_rdata  = b_rvalid_q ? res_di : '0;

endmodule

// File: tb/tb_res_ram_arbiter.sv
// tb/tb_res_ram_arbiter.sv - scoreboard bench for res_ram_arbiter
// Read data expectations are queued at grant time and compared on rvalid.
module tb_res_ram_arbiter;

  logic        clk, reset;
  logic        a_req, a_we, b_req, b_we;
  logic [13:0] a_addr, b_addr;
  logic [7:0]  a_wdata, b_wdata;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [7:0]  a_rdata, b_rdata;
  logic        res_rd, res_wr;
  logic [13:0] res_addr;
  logic [7:0]  res_do, res_di;

  logic        a_gnt1, a_rvalid1, b_gnt1, b_rvalid1, res_rd1, res_wr1;
  logic [7:0]  a_rdata1, b_rdata1, res_do1, res_di1;
  logic [13:0] res_addr1;

  logic [7:0]  ram    [16384];
  logic [7:0]  shadow [16384];
  logic [7:0]  q_a[$];
  logic [7:0]  q_b[$];
  int          n_checks = 0;
  int          n_err    = 0;

  res_ram_arbiter #(.ADDR_W(14), .DATA_W(8), .MAX_BURST(16)) u_dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .res_rd(res_rd), .res_wr(res_wr), .res_addr(res_addr),
    .res_do(res_do), .res_di(res_di));

  res_ram_arbiter #(.ADDR_W(14), .DATA_W(8), .MAX_BURST(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt1), .a_rvalid(a_rvalid1), .a_rdata(a_rdata1),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt1), .b_rvalid(b_rvalid1), .b_rdata(b_rdata1),
    .res_rd(res_rd1), .res_wr(res_wr1), .res_addr(res_addr1),
    .res_do(res_do1), .res_di(res_di1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (res_wr) ram[res_addr] <= res_do;
    if (res_rd) res_di <= ram[res_addr];
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      q_a.delete();
      q_b.delete();
    end else begin
      if (a_rvalid) begin
        if (q_a.size() == 0) check("sb_a_unexpected", 32'(a_rvalid), 32'd0);
        else check("sb_a_rdata", 32'(a_rdata), 32'(q_a.pop_front()));
      end
      if (b_rvalid) begin
        if (q_b.size() == 0) check("sb_b_unexpected", 32'(b_rvalid), 32'd0);
        else check("sb_b_rdata", 32'(b_rdata), 32'(q_b.pop_front()));
      end
      if (a_gnt && !a_we) q_a.push_back(shadow[a_addr]);
      if (a_gnt && a_we)  shadow[a_addr] = a_wdata;
      if (b_gnt && !b_we) q_b.push_back(shadow[b_addr]);
      if (b_gnt && b_we)  shadow[b_addr] = b_wdata;
    end
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) begin
      ram[i]    = 8'(i) ^ 8'h5A;
      shadow[i] = 8'(i) ^ 8'h5A;
    end
    res_di = 8'h00; res_di1 = 8'h00;
    reset = 1'b1;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;

    // reset values with requests pending
    next_cycle();
    a_req = 1; b_req = 1;
    @(negedge clk);
    check("rst_gnt", {30'd0, a_gnt, b_gnt}, 32'd0);
    check("rst_rvalid", {30'd0, a_rvalid, b_rvalid}, 32'd0);
    check("rst_strobes", {30'd0, res_rd, res_wr}, 32'd0);
    check("rst_addr", 32'(res_addr), 32'd0);
    check("rst_do", 32'(res_do), 32'd0);
    check("rst_rdata", {16'd0, a_rdata, b_rdata}, 32'd0);
    next_cycle();
    reset = 1'b0;

    // burst limit: A 16 cycles, B on 17; MAX_BURST=1 copy alternates
    a_we = 0; a_addr = 14'h0000; b_we = 0; b_addr = 14'h3FFF;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      check("t1_a_gnt", 32'(a_gnt), 32'(k <= 16));
      check("t1_b_gnt", 32'(b_gnt), 32'(k == 17));
      check("t6_a_gnt", 32'(a_gnt1), 32'(k % 2));
      check("t6_b_gnt", 32'(b_gnt1), 32'(1 - (k % 2)));
      next_cycle();
    end
    a_req = 0; b_req = 0;
    next_cycle();

    // A-only write stream
    for (int i = 0; i < 128; i++) begin
      a_req = 1; a_we = 1; a_addr = 14'(i); a_wdata = 8'(i);
      @(negedge clk);
      check("t2_gnt", {30'd0, a_gnt, b_gnt}, 32'd2);
      check("t2_wr", {30'd0, res_wr, res_rd}, 32'd2);
      check("t2_addr", 32'(res_addr), 32'(i));
      check("t2_do", 32'(res_do), 32'(i));
      next_cycle();
    end
    a_req = 0; a_we = 0;
    next_cycle();

    // B preload 0x0005 then read it back
    b_req = 1; b_we = 1; b_addr = 14'h0005; b_wdata = 8'h2A;
    @(negedge clk);
    check("t3_wgnt", 32'(b_gnt), 32'd1);
    next_cycle();
    b_we = 0;
    @(negedge clk);
    check("t3_rgnt", {30'd0, b_gnt, res_rd}, 32'd3);
    next_cycle();
    b_req = 0;
    @(negedge clk);
    check("t3_rvalid", {30'd0, b_rvalid, a_rvalid}, 32'd2);
    check("t3_rdata", 32'(b_rdata), 32'h2A);
    next_cycle();

    // A read then A write, B waiting
    a_req = 1; a_we = 0; a_addr = 14'h0010;
    b_req = 1; b_we = 0; b_addr = 14'h0020;
    @(negedge clk);
    check("t4_c1", {30'd0, a_gnt, b_gnt}, 32'd2);
    next_cycle();
    a_we = 1; a_addr = 14'h0011; a_wdata = 8'h77;
    @(negedge clk);
    check("t4_c2", {30'd0, a_gnt, b_gnt}, 32'd2);
    check("t4_rvalid", 32'(a_rvalid), 32'd1);
    check("t4_rdata", 32'(a_rdata), 32'h10);
    next_cycle();
    a_req = 0; a_we = 0;
    @(negedge clk);
    check("t4_c3", {30'd0, a_gnt, b_gnt}, 32'd1);
    next_cycle();
    b_req = 0;
    a_req = 1; a_addr = 14'h0011;
    @(negedge clk);
    check("t4_b_rdata", {23'd0, b_rvalid, b_rdata}, 32'h120);
    check("t4_c4", 32'(a_gnt), 32'd1);
    next_cycle();
    a_req = 0;
    @(negedge clk);
    check("t4_wb_rdata", {23'd0, a_rvalid, a_rdata}, 32'h177);
    next_cycle();

    // reset while a B read is in flight
    b_req = 1; b_we = 0; b_addr = 14'h3FFF;
    @(negedge clk);
    check("t5_bgnt", 32'(b_gnt), 32'd1);
    next_cycle();
    reset = 1; a_req = 1; a_we = 0; a_addr = 14'h0042;
    #1;
    check("t5_rvalid", {30'd0, a_rvalid, b_rvalid}, 32'd0);
    check("t5_gnt", {30'd0, a_gnt, b_gnt}, 32'd0);
    check("t5_res", {res_rd, res_wr, res_addr, res_do}, 32'd0);
    next_cycle();
    reset = 0;
    @(negedge clk);
    check("t5_after_gnt", {30'd0, a_gnt, b_gnt}, 32'd2);
    next_cycle();
    a_req = 0;
    @(negedge clk);
    check("t5_b_later", 32'(b_gnt), 32'd1);
    next_cycle();
    b_req = 0;
    for (int i = 0; i < 4; i++) next_cycle();
    check("sb_a_drained", 32'(q_a.size()), 32'd0);
    check("sb_b_drained", 32'(q_b.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
